// File: rtl/axi_lite_intc_pkg.sv
// Shared definitions for the AXI4-Lite interrupt controller: register map,
// response codes, channel FSM states and the vector priority encoder.
package axi_lite_intc_pkg;

  // Word offsets (byte address [7:2])
  localparam logic [5:0] REG_ISR  = 6'h00;
  localparam logic [5:0] REG_KIND = 6'h01;
  localparam logic [5:0] REG_POL  = 6'h02;
  localparam logic [5:0] REG_MER  = 6'h03;
  localparam logic [5:0] REG_IER  = 6'h04;
  localparam logic [5:0] REG_IVR  = 6'h08;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_RESP} rd_state_e;

  // Lowest set bit index, all-ones when nothing is set.
  function automatic logic [31:0] priority_idx(input logic [31:0] vec);
    logic [31:0] res;
    res = '1;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) res = 32'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_intc_mt_if.sv
// AXI4-Lite slave port bundle for the interrupt controller.
interface axi_lite_intc_mt_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/intc_src_cell.sv
// One interrupt source: polarity qualifier, edge detector and pending (ISR) bit.
module intc_src_cell (
  input  logic aclk,
  input  logic areset,
  input  logic irq_i,
  input  logic kind_i,
  input  logic pol_i,
  input  logic clr_i,
  output logic pend_o
);
  logic q, q_prev_q, pend_d, pend_q;

  assign q = irq_i ^ ~pol_i;

  // A fresh edge beats a simultaneous write-1-to-clear.
  always_comb begin
    if (kind_i) pend_d = (q & ~q_prev_q) | (pend_q & ~clr_i);
    else        pend_d = q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      q_prev_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      q_prev_q <= q;
      pend_q   <= pend_d;
    end
  end

  assign pend_o = pend_q;
endmodule

// File: rtl/axi_lite_intc_mt.sv
// AXI4-Lite interrupt controller: NUM_IRQ qualified sources fanned out to
// NUM_TARGETS irq lines, each with its own enable mask and vector register.
module axi_lite_intc_mt
  import axi_lite_intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned NUM_TARGETS = 2,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [31:0] RESET_KIND  = 32'hFFFF_FFFE
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi_lite_intc_mt_if.slave      s_axi,
  input  logic [NUM_IRQ-1:0]     irq_i,
  output logic [NUM_TARGETS-1:0] irq_o
);
  localparam logic [31:0] IRQ_MASK = 32'hFFFF_FFFF >> (32 - NUM_IRQ);

  wr_state_e wr_state_q;
  rd_state_e rd_state_q;
  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0] bresp_q, rresp_q;
  logic [31:0] rdata_q, rd_val;
  logic [ADDR_WIDTH-1:0] aw_addr_q, wr_addr;
  logic [31:0] w_data_q, wr_data, wr_mask, isr, isr_clr, kind_q, pol_q;
  logic [3:0] w_strb_q, wr_strb;
  logic [5:0] wr_word, rd_word;
  logic aw_hs, w_hs, ar_hs, have_aw, have_w, wr_fire, mer_q;
  logic [31:0] ier_q [4];
  logic [31:0] ivr [4];
  logic [NUM_TARGETS-1:0] irq_q;
  logic unused_sink;

  function automatic logic reg_ok(input logic [5:0] w);
    if (w[5:2] == REG_ISR[5:2]) return 1'b1;
    return (w[5:2] == REG_IER[5:2] || w[5:2] == REG_IVR[5:2]) && (32'(w[1:0]) < NUM_TARGETS);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old);
    return ((old & ~wr_mask) | (wr_data & wr_mask)) & IRQ_MASK;
  endfunction

  // Write path: the second half of an AW/W pair is taken straight off the bus.
  assign aw_hs   = s_axi.awvalid & awready_q;
  assign w_hs    = s_axi.wvalid & wready_q;
  assign have_aw = aw_hs | (wr_state_q == W_HAVE_AW);
  assign have_w  = w_hs | (wr_state_q == W_HAVE_W);
  assign wr_fire = have_aw & have_w;
  assign wr_addr = (wr_state_q == W_HAVE_AW) ? aw_addr_q : s_axi.awaddr;
  assign wr_data = (wr_state_q == W_HAVE_W) ? w_data_q : s_axi.wdata;
  assign wr_strb = (wr_state_q == W_HAVE_W) ? w_strb_q : s_axi.wstrb;
  assign wr_word = wr_addr[7:2];
  assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
  assign isr_clr = (wr_fire && wr_word == REG_ISR) ? (wr_data & wr_mask & IRQ_MASK) : '0;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    intc_src_cell u_src (
      .aclk   (aclk),
      .areset (areset),
      .irq_i  (irq_i[i]),
      .kind_i (kind_q[i]),
      .pol_i  (pol_q[i]),
      .clr_i  (isr_clr[i]),
      .pend_o (isr[i])
    );
  end
  if (NUM_IRQ < 32) begin : g_isr_pad
    assign isr[31:NUM_IRQ] = '0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      kind_q <= RESET_KIND & IRQ_MASK;
      pol_q  <= '0;
      mer_q  <= 1'b0;
      for (int t = 0; t < 4; t++) ier_q[t] <= '0;
    end else if (wr_fire && reg_ok(wr_word)) begin
      case (wr_word)
        REG_KIND: kind_q <= merge(kind_q);
        REG_POL:  pol_q  <= merge(pol_q);
        REG_MER:  if (wr_strb[0]) mer_q <= wr_data[0];
        default:  if (wr_word[5:2] == REG_IER[5:2]) ier_q[wr_word[1:0]] <= merge(ier_q[wr_word[1:0]]);
      endcase
    end
  end

  always_comb begin
    for (int t = 0; t < 4; t++) ivr[t] = priority_idx(isr & ier_q[t]);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) irq_q <= '0;
    else for (int t = 0; t < NUM_TARGETS; t++) irq_q[t] <= mer_q & |(isr & ier_q[t]);
  end
  assign irq_o = irq_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= s_axi.awaddr;
      if (w_hs) begin
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      unique case (wr_state_q)
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          if (have_aw && have_w) begin
            wr_state_q <= W_RESP;
            bvalid_q   <= 1'b1;
            bresp_q    <= reg_ok(wr_word) ? RESP_OKAY : RESP_SLVERR;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
          end else if (have_aw) begin
            wr_state_q <= W_HAVE_AW;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
          end else if (have_w) begin
            wr_state_q <= W_HAVE_W;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
          end else begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  // Read path samples register state before any same-cycle write lands.
  assign ar_hs   = s_axi.arvalid & arready_q;
  assign rd_word = s_axi.araddr[7:2];

  always_comb begin
    rd_val = '0;
    if (rd_word[5:2] == REG_IER[5:2])      rd_val = ier_q[rd_word[1:0]];
    else if (rd_word[5:2] == REG_IVR[5:2]) rd_val = ivr[rd_word[1:0]];
    else begin
      case (rd_word)
        REG_ISR:  rd_val = isr;
        REG_KIND: rd_val = kind_q;
        REG_POL:  rd_val = pol_q;
        REG_MER:  rd_val = {31'b0, mer_q};
        default:  rd_val = '0;
      endcase
    end
    if (!reg_ok(rd_word)) rd_val = '0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q    <= rd_val;
            rresp_q    <= reg_ok(rd_word) ? RESP_OKAY : RESP_SLVERR;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= R_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi.rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign unused_sink = ^{wr_addr[1:0], s_axi.araddr[1:0], isr_clr};
endmodule

// File: tb/tb_axi_lite_intc_mt.sv
// Directed bench for axi_lite_intc_mt with NUM_IRQ=8, NUM_TARGETS=2.
module tb_axi_lite_intc_mt;
  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] irq_i;
  logic [1:0] irq_o;
  int total = 0;
  int bad = 0;
  logic [31:0] d;
  logic [1:0]  r;

  axi_lite_intc_mt_if #(.ADDR_WIDTH(8)) bus ();

  axi_lite_intc_mt #(
    .NUM_IRQ     (8),
    .NUM_TARGETS (2),
    .ADDR_WIDTH  (8),
    .RESET_KIND  (32'hFFFF_FFFE)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axi  (bus),
    .irq_i  (irq_i),
    .irq_o  (irq_o)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_done = 0, aw_now, w_now;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      tick();
      if (aw_now) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_now) begin w_done = 1; bus.wvalid = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("wr_accept", 32'(aw_done && w_done), 1);
    bus.bready = 1'b1;
    resp = 2'b11;
    for (int n = 0; n < 50 && !b_done; n++) begin
      if (bus.bvalid) begin resp = bus.bresp; b_done = 1; end
      tick();
    end
    bus.bready = 1'b0;
    check("wr_bvalid", 32'(b_done), 1);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0, ar_now;
    bus.araddr = addr; bus.arvalid = 1'b1;
    for (int n = 0; n < 50 && !ar_done; n++) begin
      ar_now = bus.arready;
      tick();
      if (ar_now) ar_done = 1;
    end
    bus.arvalid = 1'b0;
    check("rd_accept", 32'(ar_done), 1);
    bus.rready = 1'b1;
    data = 32'hDEAD_BEEF; resp = 2'b11;
    for (int n = 0; n < 50 && !r_done; n++) begin
      if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; r_done = 1; end
      tick();
    end
    bus.rready = 1'b0;
    check("rd_rvalid", 32'(r_done), 1);
  endtask

  task automatic wr_ok(input logic [7:0] addr, input logic [31:0] data);
    logic [1:0] resp;
    wr(addr, data, 4'hF, resp);
    check("bresp_okay", resp, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] data;
    logic [1:0]  resp;
    rd(addr, data, resp);
    check(tag, data, exp);
    check({tag, "_rresp"}, resp, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    irq_i = 8'h02;
    areset = 1'b1;
    tick(3);
    areset = 1'b0;
    tick(3);

    // Out of reset POL=0: bit0 (level, low-active) pends, edge bits 2..7 see a rising q.
    check("irq_o_rst", irq_o, 0);
    rd_chk("kind_rst", 8'h04, 32'h0000_00FE);
    rd_chk("ivr0_rst", 8'h20, 32'hFFFF_FFFF);
    rd_chk("isr_rst", 8'h00, 32'h0000_00FD);

    wr_ok(8'h04, 32'hFC);
    wr_ok(8'h08, 32'h08);
    wr_ok(8'h00, 32'hFF);
    rd_chk("isr_clean", 8'h00, 32'h01);
    wr_ok(8'h10, 32'h08);
    wr_ok(8'h0C, 32'h01);
    check("irq_o_idle", irq_o, 0);

    irq_i[3] = 1'b1;
    tick();
    irq_i[3] = 1'b0;
    check("irq_o_lat1", irq_o, 2'b00);
    tick();
    check("irq_o_lat2", irq_o, 2'b01);
    rd_chk("isr_edge", 8'h00, 32'h09);
    rd_chk("ivr0_3", 8'h20, 32'd3);
    wr_ok(8'h00, 32'h08);
    tick();
    check("irq_o_w1c", irq_o, 0);
    rd_chk("ivr0_none", 8'h20, 32'hFFFF_FFFF);

    wr_ok(8'h14, 32'h02);
    irq_i[1] = 1'b0;
    tick(2);
    check("irq_o_lvl", irq_o, 2'b10);
    wr_ok(8'h00, 32'h02);
    rd_chk("isr_lvl_w1c", 8'h00, 32'h03);
    check("irq_o_lvl_hold", irq_o, 2'b10);
    irq_i[1] = 1'b1;
    tick(2);
    check("irq_o_lvl_rel", irq_o, 0);
    rd_chk("isr_lvl_rel", 8'h00, 32'h01);

    wr_ok(8'h08, 32'h2C);
    wr_ok(8'h10, 32'h24);
    irq_i = 8'h26;
    tick();
    irq_i = 8'h02;
    tick();
    rd_chk("ivr0_2", 8'h20, 32'd2);
    check("irq_o_prio", irq_o, 2'b01);
    wr_ok(8'h00, 32'h04);
    rd_chk("ivr0_5", 8'h20, 32'd5);
    wr_ok(8'h00, 32'h20);
    rd_chk("ivr0_empty", 8'h20, 32'hFFFF_FFFF);

    // W leads AW by three cycles; B is back-pressured for four.
    bus.wdata = 32'h5A; bus.wstrb = 4'b0001; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("have_w_ready", {bus.wready, bus.awready}, 2'b01);
    tick(2);
    bus.awaddr = 8'h14; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b_hold", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
      tick();
    end
    bus.bready = 1'b1;
    check("b_resp", bus.bresp, 0);
    tick();
    bus.bready = 1'b0;
    check("b_done", bus.bvalid, 0);
    rd_chk("ier1_order", 8'h14, 32'h5A);
    wr(8'h14, 32'hFFFF_FFFF, 4'b1110, r);
    check("bresp_strb", r, 0);
    rd_chk("ier1_strb", 8'h14, 32'h5A);

    rd(8'h40, d, r);
    check("bad_rdata", d, 0);
    check("bad_rresp", r, 2'b10);
    wr(8'h40, 32'h1, 4'hF, r);
    check("bad_bresp", r, 2'b10);
    rd(8'h18, d, r);
    check("ier2_rresp", r, 2'b10);

    // New edge and W1C of the same bit land on one clock.
    bus.awaddr = 8'h00; bus.awvalid = 1'b1;
    bus.wdata = 32'h08; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    irq_i[3] = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    irq_i[3] = 1'b0;
    check("coll_bvalid", bus.bvalid, 1);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    rd_chk("isr_coll", 8'h00, 32'h09);

    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("have_aw_ready", {bus.awready, bus.wready}, 2'b01);
    check("irq_o_pre_rst", irq_o, 2'b10);
    areset = 1'b1;
    #1;
    check("rst_valids", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 0);
    check("rst_irq_o", irq_o, 0);
    tick();
    areset = 1'b0;
    tick(3);
    rd_chk("kind_after", 8'h04, 32'h0000_00FE);
    rd_chk("ier1_after", 8'h14, 32'h0);
    rd_chk("mer_after", 8'h0C, 32'h0);
    rd_chk("isr_after", 8'h00, 32'h0000_00FD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
